// File: rtl/address_gen_nd.sv
// address_gen_nd: nested-loop word address generator for a Versat memory unit.
// Emits one byte address per valid/ready handshake across LOOPS nested levels
// (level 0 innermost), with a duty window on level 0 and per-level last flags.
// Optional: define ADDRESS_GEN_ND_BOUNDS_EN to add limit_i / oob_o bounds checking.
module address_gen_nd #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 10,
  parameter int LOOPS   = 4,
  parameter int DELAY_W = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     run_i,
  input  logic [ADDR_W-1:0]        start_i,
  input  logic [DELAY_W-1:0]       delay_i,
  input  logic [CNT_W-1:0]         duty_i,
  input  logic [LOOPS*CNT_W-1:0]   count_i,
  input  logic [LOOPS*ADDR_W-1:0]  incr_i,
`ifdef ADDRESS_GEN_ND_BOUNDS_EN
  input  logic [ADDR_W-1:0]        limit_i,
  output logic                     oob_o,
`endif
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [ADDR_W-1:0]        addr_o,
  output logic                     store_o,
  output logic [LOOPS-1:0]         level_last_o,
  output logic                     last_o,
  output logic                     done_o
);

  localparam int OFFSET_W = $clog2(DATA_W / 8);

  // configuration captured at run_i
  logic [CNT_W-1:0]   count_q [LOOPS];
  logic [ADDR_W-1:0]  incr_q  [LOOPS];
  logic [CNT_W-1:0]   duty_q;
`ifdef ADDRESS_GEN_ND_BOUNDS_EN
  logic [ADDR_W-1:0]  limit_q;
`endif

  logic [CNT_W-1:0]   cnt  [LOOPS];
  logic [ADDR_W-1:0]  base [LOOPS];
  logic [DELAY_W-1:0] delay_ctr;

  logic [CNT_W-1:0]   eff [LOOPS];
  logic [CNT_W-1:0]   eff_duty;
  logic [LOOPS-1:0]   term;
  logic [LOOPS-1:0]   inc_oh;
  logic [LOOPS-1:0]   clr;
  logic [LOOPS-1:0]   base_ld;
  logic               all_term;
  logic               in_duty;
  logic [ADDR_W-1:0]  sel_base;
  logic [ADDR_W-1:0]  sel_incr;
  logic [ADDR_W-1:0]  new_addr;
  logic [ADDR_W-1:0]  incr0_sh;
  logic [ADDR_W-1:0]  start_sh;

  assign start_sh = start_i << OFFSET_W;
  assign incr0_sh = incr_q[0] << OFFSET_W;

  // per-level terminal detection; a zero count behaves as a single iteration
  always_comb begin
    for (int k = 0; k < LOOPS; k++) begin
      eff[k]  = (count_q[k] == '0) ? CNT_W'(1) : count_q[k];
      term[k] = ({1'b0, cnt[k]} + (CNT_W+1)'(1)) >= {1'b0, eff[k]};
    end
    eff_duty = (duty_q == '0) ? eff[0] : duty_q;
    in_duty  = cnt[0] < eff_duty;
  end

  // pick the lowest non-terminal level: it increments, everything below it
  // wraps to zero and reloads its base from the new address
  always_comb begin
    logic found;
    found    = 1'b0;
    inc_oh   = '0;
    clr      = '0;
    base_ld  = '0;
    sel_base = '0;
    sel_incr = '0;
    for (int k = 0; k < LOOPS; k++) begin
      if (!found) begin
        base_ld[k] = 1'b1;
        if (term[k]) begin
          clr[k] = 1'b1;
        end else begin
          inc_oh[k] = 1'b1;
          sel_base  = base[k];
          sel_incr  = incr_q[k];
          found     = 1'b1;
        end
      end
    end
    all_term = !found;
    new_addr = sel_base + (sel_incr << OFFSET_W);
  end

  // boundary flags are qualified by valid so they never show on idle cycles
  always_comb begin
    logic acc;
    acc          = valid_o;
    level_last_o = '0;
    for (int k = 0; k < LOOPS; k++) begin
      acc             = acc & term[k];
      level_last_o[k] = acc;
    end
    last_o  = level_last_o[LOOPS-1];
    store_o = valid_o & in_duty;
  end

  // config capture, start delay, and loop-nest advance on each handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      addr_o    <= '0;
      done_o    <= 1'b1;
      duty_q    <= '0;
      delay_ctr <= '0;
      for (int k = 0; k < LOOPS; k++) begin
        count_q[k] <= '0;
        incr_q[k]  <= '0;
        cnt[k]     <= '0;
        base[k]    <= '0;
      end
`ifdef ADDRESS_GEN_ND_BOUNDS_EN
      limit_q <= '0;
      oob_o   <= 1'b0;
`endif
    end else if (run_i) begin
      // a run while busy simply abandons the current nest
      addr_o    <= start_sh;
      done_o    <= 1'b0;
      duty_q    <= duty_i;
      delay_ctr <= delay_i;
      valid_o   <= (delay_i == '0);
      for (int k = 0; k < LOOPS; k++) begin
        count_q[k] <= count_i[k*CNT_W +: CNT_W];
        incr_q[k]  <= incr_i[k*ADDR_W +: ADDR_W];
        cnt[k]     <= '0;
        base[k]    <= start_sh;
      end
`ifdef ADDRESS_GEN_ND_BOUNDS_EN
      limit_q <= limit_i;
      oob_o   <= 1'b0;
`endif
    end else begin
      if (delay_ctr != '0) begin
        delay_ctr <= delay_ctr - DELAY_W'(1);
        if (delay_ctr == DELAY_W'(1)) begin
          valid_o <= 1'b1;
        end
      end
      if (valid_o && ready_i) begin
`ifdef ADDRESS_GEN_ND_BOUNDS_EN
        if (addr_o >= limit_q) begin
          oob_o <= 1'b1;
        end
`endif
        if (all_term) begin
          valid_o <= 1'b0;
          done_o  <= 1'b1;
        end else if (inc_oh[0]) begin
          // outside the duty window the address parks while the count runs on
          if (in_duty) begin
            addr_o <= addr_o + incr0_sh;
          end
          cnt[0] <= cnt[0] + CNT_W'(1);
        end else begin
          addr_o <= new_addr;
          for (int k = 0; k < LOOPS; k++) begin
            if (clr[k]) begin
              cnt[k] <= '0;
            end
            if (inc_oh[k]) begin
              cnt[k] <= cnt[k] + CNT_W'(1);
            end
          end
          for (int k = 1; k < LOOPS; k++) begin
            if (base_ld[k]) begin
              base[k] <= new_addr;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/address_gen_nd.md
Name: address_gen_nd

Overview:
- Next-generation memory-side address generator for Versat memory units.
- Replaces the fixed three-level per/iter address unit with LOOPS generic nested loop levels, a duty window on the innermost level, and per-level boundary flags.
- Sits between a unit's configuration registers and its local memory port.
- Produces one word address per valid/ready handshake until the loop nest is exhausted.

Parameters:
- ADDR_W, 10, memory address width (byte-granular output).
- DATA_W, 32, memory word width; OFFSET_W = clog2(DATA_W/8).
- CNT_W, 10, per-level loop count width.
- LOOPS, 4, number of nested loop levels (>=1); level 0 is innermost.
- DELAY_W, 7, start-delay counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- run_i  in  1  single-cycle start pulse; latches config and restarts the block
- start_i  in  ADDR_W  start word address
- delay_i  in  DELAY_W  cycles from run_i until first valid
- duty_i  in  CNT_W  level-0 active window; 0 means full period
- count_i  in  LOOPS*CNT_W  packed iteration counts; level k uses bits [k*CNT_W +: CNT_W]
- incr_i  in  LOOPS*ADDR_W  packed signed word increments per level
- valid_o  out  1  addr_o/store_o valid
- ready_i  in  1  consumer accepts current address
- addr_o  out  ADDR_W  byte address
- store_o  out  1  current slot inside duty window
- level_last_o  out  LOOPS  bit k set when levels 0..k are all at terminal count
- last_o  out  1  final address of the nest (= level_last_o[LOOPS-1] & valid_o)
- done_o  out  1  idle/finished

Behaviour:
- Reset values: valid_o=0, addr_o=0, store_o=0, level_last_o=0, last_o=0, done_o=1. All counters and base registers are 0.
- Effective count: eff_k = (count_k==0) ? 1 : count_k. Level k is terminal when cnt_k+1 >= eff_k.
- run_i: addr_o and base[1..LOOPS-1] <= start_i<<OFFSET_W; all cnt_k <= 0; done_o <= 0; delay_ctr <= delay_i.
  - valid_o <= (delay_i==0) on the cycle after run_i.
  - run_i while busy aborts the current nest and restarts; it takes priority over an in-flight handshake.
- Delay: while delay_ctr != 0, decrement it. valid_o rises the cycle delay_ctr goes 1->0, so the first valid appears delay_i+1 cycles after run_i.
- Advance happens on valid_o & ready_i. Let m be the lowest non-terminal level.
  - m==0: if cnt_0 < eff_duty, addr_o += incr_0<<OFFSET_W; otherwise addr_o holds. Then cnt_0++.
  - m>=1: new = base[m] + (incr_m<<OFFSET_W). Set addr_o <= new, base[j] <= new for 1<=j<=m, cnt_j <= 0 for j<m, cnt_m++.
  - No non-terminal level: valid_o <= 0, done_o <= 1, counters hold.
- eff_duty = (duty_i==0) ? eff_0 : duty_i. store_o = valid_o & (cnt_0 < eff_duty).
- Total handshakes per run = product of eff_k.
- Arithmetic: incr is sign-extended to ADDR_W, shifted left by OFFSET_W, and wraps modulo 2^ADDR_W. No saturation.
- valid_o holds with addr_o stable while ready_i=0.
- level_last_o and last_o are combinational from the counters, gated by valid_o.
- Config inputs are sampled only at run_i and held internally. Changing them mid-run has no effect.
- Asynchronous reset mid-run returns immediately to reset values. A new run_i is required to start again.

Optional Feature:
- Macro: ADDRESS_GEN_ND_BOUNDS_EN.
- When defined, adds input limit_i [ADDR_W] (sampled at run_i) and output oob_o [1].
  - oob_o is set sticky when a valid addr_o >= limit_i is handshaken.
  - The offending handshake still completes.
  - oob_o is cleared by run_i or reset.
- When undefined, neither port exists and there is no bounds logic.

Test Plan:
- LOOPS=4, DATA_W=32, start=4, counts {3,2,0,0}, incr {1,10,0,0}, delay=0, ready=1 -> addr_o sequence 16,20,24,56,60,64. last_o on the 6th address; done_o=1 the next cycle.
- counts {4,1,1,1}, duty=2, incr0=1, start=0 -> addresses 0,4,8,8. store_o sequence 1,1,0,0.
- delay=5, counts {1,...} -> valid_o first high exactly 6 cycles after run_i. Holding ready_i=0 for 3 cycles keeps addr_o stable.
- incr0=-1, start=0, counts {3,...}, ADDR_W=10 -> addresses 0, 1020, 1016 (wrap).
- Assert rst_i mid-nest, then re-run with counts {2,2} -> outputs return to reset values; new sequence starts from start_i with 4 handshakes. run_i issued mid-nest restarts similarly.
- ADDRESS_GEN_ND_BOUNDS_EN, limit=12, counts {5}, incr0=1, start=0 -> oob_o rises after the handshake at addr 12 and stays high until the next run_i.
